// File: rtl/fft_pkg.sv
// Shared types and constants for the 8-point FFT front end: sample/frame
// types, ping-pong bank states and the launcher FSM states.
package fft_pkg;

    localparam int N_POINTS = 8;
    localparam int SAMPLE_W = 12;
    localparam int IDX_W    = $clog2(N_POINTS);

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef sample_t [0:N_POINTS-1]     frame_t;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_IN_FLIGHT
    } bank_state_e;

    typedef enum logic [1:0] {
        L_IDLE,
        L_LAUNCH,
        L_WAIT
    } launch_state_e;

    // A bank may take samples only while it is not holding a complete frame.
    function automatic logic bank_writable(input bank_state_e s);
        return (s == BANK_EMPTY) || (s == BANK_FILLING);
    endfunction

endpackage

// File: rtl/fft_sample_bank.sv
// One 8-entry sample bank: single indexed write port, whole-frame read.
// Occupancy state is tracked by the parent loader.
module fft_sample_bank
    import fft_pkg::*;
(
    input  logic                               CLK,
    input  logic                               wr_en_i,
    input  logic [IDX_W-1:0]                   wr_idx_i,
    input  logic [SAMPLE_W-1:0]                wr_data_i,
    output logic [0:N_POINTS-1][SAMPLE_W-1:0]  frame_o
);

    frame_t mem_q;

    // NOTE: storage is deliberately not reset; every index is rewritten
    // before a bank can become FULL, so stale contents are never launched.
    always_ff @(posedge CLK) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign frame_o = mem_q;

endmodule

// File: rtl/fft_frame_loader.sv
// Serial-to-parallel ping-pong frame loader feeding the 8-point FFT core.
// Define FFT_LOADER_STATUS_EN to add the sync_err_cnt resync-discard counter.
module fft_frame_loader
    import fft_pkg::*;
(
    input  logic                               CLK,
    input  logic                               nRESET,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [SAMPLE_W-1:0]                s_data,
    input  logic                               s_first,
    output logic [0:N_POINTS-1][SAMPLE_W-1:0]  frame_out,
    output logic                               fft_enable,
    input  logic                               fft_finish,
    output logic                               busy
`ifdef FFT_LOADER_STATUS_EN
    ,
    output logic [7:0]                         sync_err_cnt
`endif
);

    bank_state_e   bank_q [2];
    bank_state_e   bank_d [2];
    logic [IDX_W-1:0] wp_q, wp_d;
    logic          wb_q, wb_d;
    logic          last_filled_q, last_filled_d;
    logic          inflight_q;
    launch_state_e state_q;
    logic          fft_enable_q;
    logic          busy_q;
    frame_t        frame_q;

    logic [0:N_POINTS-1][SAMPLE_W-1:0] bank_frame [2];
    logic          accept;
    logic          full_a, full_b;
    logic          launch_go, finish_go, launch_bank;
    logic [IDX_W-1:0] wr_idx;

    assign s_ready  = bank_writable(bank_q[wb_q]);
    assign accept   = s_valid & s_ready;
    assign wr_idx   = s_first ? '0 : wp_q;

    assign full_a   = (bank_q[0] == BANK_FULL);
    assign full_b   = (bank_q[1] == BANK_FULL);
    // With both banks full the older one is the bank not filled most recently.
    assign launch_bank = (full_a && full_b) ? ~last_filled_q : full_b;
    assign launch_go   = (state_q == L_IDLE) && (full_a || full_b);
    assign finish_go   = (state_q == L_WAIT) && fft_finish;

    fft_sample_bank u_bank_a (
        .CLK       (CLK),
        .wr_en_i   (accept && !wb_q),
        .wr_idx_i  (wr_idx),
        .wr_data_i (s_data),
        .frame_o   (bank_frame[0])
    );

    fft_sample_bank u_bank_b (
        .CLK       (CLK),
        .wr_en_i   (accept && wb_q),
        .wr_idx_i  (wr_idx),
        .wr_data_i (s_data),
        .frame_o   (bank_frame[1])
    );

    // Launch, release and write never target the same bank in one cycle,
    // so the three updates below compose without priority conflicts.
    always_comb begin
        bank_d        = bank_q;
        wp_d          = wp_q;
        wb_d          = wb_q;
        last_filled_d = last_filled_q;

        if (launch_go) begin
            bank_d[launch_bank] = BANK_IN_FLIGHT;
        end
        if (finish_go) begin
            bank_d[inflight_q] = BANK_EMPTY;
        end

        if (accept) begin
            if (s_first) begin
                wp_d         = IDX_W'(1);
                bank_d[wb_q] = BANK_FILLING;
            end else if (wp_q == IDX_W'(N_POINTS - 1)) begin
                wp_d          = '0;
                bank_d[wb_q]  = BANK_FULL;
                wb_d          = ~wb_q;
                last_filled_d = wb_q;
            end else begin
                wp_d         = wp_q + IDX_W'(1);
                bank_d[wb_q] = BANK_FILLING;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of its neighbours.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            bank_q[0]     <= BANK_EMPTY;
            bank_q[1]     <= BANK_EMPTY;
            wp_q          <= '0;
            wb_q          <= 1'b0;
            last_filled_q <= 1'b0;
        end else begin
            bank_q[0]     <= bank_d[0];
            bank_q[1]     <= bank_d[1];
            wp_q          <= wp_d;
            wb_q          <= wb_d;
            last_filled_q <= last_filled_d;
        end
    end

    // Launcher: every output is registered; IDLE always lasts at least one
    // cycle after a finish before the next launch.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q      <= L_IDLE;
            fft_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            inflight_q   <= 1'b0;
            frame_q      <= '0;
        end else begin
            fft_enable_q <= 1'b0;
            case (state_q)
                L_IDLE: begin
                    if (launch_go) begin
                        state_q      <= L_LAUNCH;
                        fft_enable_q <= 1'b1;
                        busy_q       <= 1'b1;
                        inflight_q   <= launch_bank;
                        frame_q      <= bank_frame[launch_bank];
                    end
                end
                L_LAUNCH: begin
                    state_q <= L_WAIT;
                end
                L_WAIT: begin
                    if (fft_finish) begin
                        state_q <= L_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= L_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FFT_LOADER_STATUS_EN
    logic [7:0] sync_err_q;

    // Counts partial frames thrown away by a resync; saturates at 255.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            sync_err_q <= '0;
        end else if (accept && s_first && (wp_q != '0) && (sync_err_q != 8'hFF)) begin
            sync_err_q <= sync_err_q + 8'd1;
        end
    end

    assign sync_err_cnt = sync_err_q;
`endif

    assign frame_out  = frame_q;
    assign fft_enable = fft_enable_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed self-checking bench for fft_frame_loader; builds with or without
// FFT_LOADER_STATUS_EN.
module tb_fft_frame_loader;
    import fft_pkg::*;

    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_first = 1'b0;
    logic        fft_finish = 1'b0;
    logic [11:0] s_data = '0;
    logic        s_ready;
    logic        fft_enable;
    logic        busy;
    logic [0:7][11:0] frame_out;
`ifdef FFT_LOADER_STATUS_EN
    logic [7:0]  sync_err_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [0:7][11:0] exp_f;
    logic [11:0]      f0;

    always #5 CLK = ~CLK;

    fft_frame_loader dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_first    (s_first),
        .frame_out  (frame_out),
        .fft_enable (fft_enable),
        .fft_finish (fft_finish),
        .busy       (busy)
`ifdef FFT_LOADER_STATUS_EN
        ,
        .sync_err_cnt (sync_err_cnt)
`endif
    );

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one sample (bounded wait for s_ready); returns at the negedge
    // after the accepting edge.
    task automatic push(input logic [11:0] d, input logic f);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_first = f;
        while (!s_ready && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (!s_ready) check("push_ready_timeout", {95'b0, s_ready}, 96'd1);
        @(negedge CLK);
        s_valid = 1'b0;
        s_first = 1'b0;
    endtask

    task automatic finish_pulse();
        fft_finish = 1'b1;
        @(negedge CLK);
        fft_finish = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_s_ready",    {95'b0, s_ready},    96'd1);
        check("rst_fft_enable", {95'b0, fft_enable}, 96'd0);
        check("rst_busy",       {95'b0, busy},       96'd0);
        check("rst_frame_out",  frame_out,           96'd0);
`ifdef FFT_LOADER_STATUS_EN
        check("rst_sync_err",   {88'b0, sync_err_cnt}, 96'd0);
`endif
        repeat (2) @(negedge CLK);
        nRESET = 1'b1;
        @(negedge CLK);

        // Samples 1..8 into bank A, launch one cycle after the 8th accept.
        for (int i = 0; i < 8; i++) push(12'(i + 1), 1'b0);
        check("t1_no_early_enable", {95'b0, fft_enable}, 96'd0);
        @(negedge CLK);
        for (int i = 0; i < 8; i++) exp_f[i] = 12'(i + 1);
        check("t1_enable",  {95'b0, fft_enable}, 96'd1);
        check("t1_busy",    {95'b0, busy},       96'd1);
        check("t1_frame",   frame_out,           exp_f);
        @(negedge CLK);
        check("t1_enable_one_cycle", {95'b0, fft_enable}, 96'd0);
        check("t1_busy_wait",        {95'b0, busy},       96'd1);

        // Fill bank B while A is in flight; input then stalls.
        for (int i = 0; i < 8; i++) push(12'h100 + 12'(i), 1'b0);
        check("t2_stall_ready", {95'b0, s_ready}, 96'd0);
        check("t2_frame_held",  frame_out,        exp_f);
        s_valid = 1'b1;
        s_data  = 12'h200;
        repeat (3) @(negedge CLK);
        check("t2_still_stalled", {95'b0, s_ready}, 96'd0);
        check("t2_busy_stalled",  {95'b0, busy},    96'd1);
        finish_pulse();
        check("t2_idle_after_finish",  {95'b0, busy},       96'd0);
        check("t2_no_enable_in_idle",  {95'b0, fft_enable}, 96'd0);
        check("t2_ready_after_finish", {95'b0, s_ready},    96'd1);
        @(negedge CLK);
        s_valid = 1'b0;
        for (int i = 0; i < 8; i++) exp_f[i] = 12'h100 + 12'(i);
        check("t2_enable_bank_b", {95'b0, fft_enable}, 96'd1);
        check("t2_frame_bank_b",  frame_out,           exp_f);
        for (int i = 1; i < 8; i++) push(12'h200 + 12'(i), 1'b0);
        check("t2_both_full_ready", {95'b0, s_ready}, 96'd0);
        finish_pulse();
        @(negedge CLK);
        for (int i = 0; i < 8; i++) exp_f[i] = 12'h200 + 12'(i);
        check("t2_enable_stalled_frame", {95'b0, fft_enable}, 96'd1);
        check("t2_stalled_not_lost",     frame_out,           exp_f);

        // 8th accept into B coincides with finish of A.
        for (int i = 0; i < 7; i++) push(12'h300 + 12'(i), 1'b0);
        s_valid    = 1'b1;
        s_data     = 12'h307;
        fft_finish = 1'b1;
        @(negedge CLK);
        s_valid    = 1'b0;
        fft_finish = 1'b0;
        check("t4_ready_no_gap", {95'b0, s_ready}, 96'd1);
        check("t4_idle",         {95'b0, busy},    96'd0);
        @(negedge CLK);
        for (int i = 0; i < 8; i++) exp_f[i] = 12'h300 + 12'(i);
        check("t4_enable", {95'b0, fft_enable}, 96'd1);
        check("t4_frame",  frame_out,           exp_f);

        // Partial frame discarded by s_first.
        for (int i = 0; i < 3; i++) push(12'h010 + 12'(i), 1'b0);
        push(12'h7FF, 1'b1);
        for (int i = 1; i < 8; i++) push(12'h020 + 12'(i), 1'b0);
`ifdef FFT_LOADER_STATUS_EN
        check("t3_sync_err_cnt", {88'b0, sync_err_cnt}, 96'd1);
`endif
        finish_pulse();
        @(negedge CLK);
        exp_f[0] = 12'h7FF;
        for (int i = 1; i < 8; i++) exp_f[i] = 12'h020 + 12'(i);
        f0 = frame_out[0];
        check("t3_enable",    {95'b0, fft_enable}, 96'd1);
        check("t3_frame0",    {84'b0, f0},         96'h7FF);
        check("t3_frame",     frame_out,           exp_f);

        // Reset in WAIT with bank B full.
        for (int i = 0; i < 8; i++) push(12'h400 + 12'(i), 1'b0);
        check("t5_ready_full", {95'b0, s_ready}, 96'd0);
        nRESET = 1'b0;
        #1;
        check("t5_rst_enable", {95'b0, fft_enable}, 96'd0);
        check("t5_rst_busy",   {95'b0, busy},       96'd0);
        check("t5_rst_frame",  frame_out,           96'd0);
        check("t5_rst_ready",  {95'b0, s_ready},    96'd1);
`ifdef FFT_LOADER_STATUS_EN
        check("t5_rst_sync_err", {88'b0, sync_err_cnt}, 96'd0);
`endif
        @(negedge CLK);
        @(negedge CLK);
        nRESET = 1'b1;
        @(negedge CLK);
        check("t5_no_stale_launch", {95'b0, busy}, 96'd0);

        // Signed extremes pass bit-exact; finish during LAUNCH is ignored.
        for (int i = 0; i < 8; i++) begin
            exp_f[i] = (i % 2 == 0) ? 12'h800 : 12'h7FF;
            push(exp_f[i], 1'b0);
        end
        @(negedge CLK);
        check("t6_enable", {95'b0, fft_enable}, 96'd1);
        check("t6_frame",  frame_out,           exp_f);
        finish_pulse();
        check("t6_finish_in_launch_ignored", {95'b0, busy}, 96'd1);
        finish_pulse();
        check("t6_finish_in_wait", {95'b0, busy}, 96'd0);
        check("t6_frame_holds",    frame_out,     exp_f);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
